univ_shift_reg: RTL and testbench
=================================

Name: univ_shift_reg

Overview:
Parametrised universal shift register, successor to the team's fixed 4-bit serial-in/serial-out shifters.
- Supports hold, shift left/right, rotate left/right and parallel load, with serial and parallel I/O.
- Supports single-step operation and counted bursts with a busy/done handshake.
- Used as a generic serialiser/deserialiser and data-alignment stage in lab datapaths.

Parameters:
WIDTH, 8, register width in bits (>=2)
CNT_W, 4, width of burst shift count (max burst = 2^CNT_W-1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
en  in  1  single-step enable (applies mode for one edge while idle)
mode  in  3  000 hold, 001 shl, 010 shr, 011 rol, 100 ror, 101 load, others = hold
sin_lsb  in  1  serial bit entering LSB on shl
sin_msb  in  1  serial bit entering MSB on shr
pdata  in  WIDTH  parallel load data
start  in  1  launch burst of count steps using mode
count  in  CNT_W  burst length
q  out  WIDTH  register contents
sout_msb  out  1  q[WIDTH-1]
sout_lsb  out  1  q[0]
busy  out  1  burst in progress
done  out  1  one-cycle pulse when burst completes

Behaviour:
- Reset: q=0, busy=0, done=0, state IDLE, internal count=0, latched mode=hold. rst overrides all inputs, including mid-burst (burst aborted, no done pulse).
- Step ops:
  - shl: q <= {q[W-2:0], sin_lsb}
  - shr: q <= {sin_msb, q[W-1:1]}
  - rol: q <= {q[W-2:0], q[W-1]}
  - ror: q <= {q[0], q[W-1:1]}
  - load: q <= pdata
  - hold/reserved: q unchanged
- sout_msb/sout_lsb are combinational taps of q (zero latency).
- FSM states: IDLE, RUN.
- IDLE, start=1 (priority over en):
  - mode=load or count=0: load applied (load case) or q unchanged (count=0); done=1 next cycle; stay IDLE; busy stays 0.
  - otherwise: latch mode and count; busy=1; go to RUN. No shift on this edge.
- IDLE, start=0, en=1: apply mode for this edge only; done stays 0.
- RUN:
  - Each edge applies the latched mode and decrements the counter.
  - On the edge performing the last step: state->IDLE, busy->0, done->1 for one cycle.
  - Burst of N gives busy high for exactly N cycles, N shifts, then done.
  - Serial inputs are sampled live each RUN edge; mode, count, en, pdata and start are ignored while busy. A start during RUN is dropped, not queued.
- done is registered, high exactly one cycle, never concurrent with busy.
- A start on the cycle done is high is accepted normally.

Optional Feature:
- Macro USR_PARITY_EN.
- Defined: extra output port parity (1 bit), registered, equal to XOR of the next q, so it is valid in the same cycle as q. Reset value 0.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package usr_pkg:
  - mode encodings MODE_HOLD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_LOAD (3-bit localparams)
  - FSM state encodings ST_IDLE, ST_RUN
- Sub-module usr_step: combinational next-value function. Inputs q, mode, sin_lsb, sin_msb, pdata; output q_next. Shared by the single-step and burst paths.

Test Plan:
- WIDTH=8. rst=1 for 2 cycles, then en=1 mode=load pdata=0xA5 -> q=0xA5, sout_msb=1, sout_lsb=1, busy=0; parity=0 if USR_PARITY_EN.
- q=0xA5, en=1 mode=shl sin_lsb=1 for one edge -> q=0x4B; then mode=hold for 3 edges -> q stays 0x4B.
- q=0x00, en=1 mode=shr sin_msb=1 for 4 edges -> q=0x80, 0xC0, 0xE0, 0xF0.
- q=0x81, start=1 mode=rol count=3 -> busy high 3 cycles, q=0x03, 0x06, 0x0C, then done=1 for one cycle with busy=0. A second start during busy is ignored, with q and timing unchanged.
- start=1 mode=shl count=0 on q=0x3C -> done=1 next cycle, busy never high, q=0x3C.
- start mode=ror count=5 on q=0x01, assert rst after 2 shifts -> next edge q=0x00, busy=0, no done pulse; a new burst afterwards behaves normally.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: mode and FSM state encodings for univ_shift_reg
package usr_pkg;
  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_ROL  = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/usr_step.sv
// usr_step: combinational next value of the shift register for one step of a mode
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pdata,
  output logic [WIDTH-1:0] q_next
);
  always_comb
    q_next = mode == MODE_SHL  ? {q[WIDTH-2:0], sin_lsb} :
             mode == MODE_SHR  ? {sin_msb, q[WIDTH-1:1]} :
             mode == MODE_ROL  ? {q[WIDTH-2:0], q[WIDTH-1]} :
             mode == MODE_ROR  ? {q[0], q[WIDTH-1:1]} :
             mode == MODE_LOAD ? pdata : q;
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with single-step and counted bursts; USR_PARITY_EN adds a registered parity output
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             sin_lsb,
  input  logic             sin_msb,
  input  logic [WIDTH-1:0] pdata,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] q,
  output logic             sout_msb,
  output logic             sout_lsb,
  output logic             busy,
  output logic             done
`ifdef USR_PARITY_EN
  ,
  output logic             parity
`endif
);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       mode_l, mode_n;
  logic [WIDTH-1:0] q_n, q_step;
  logic             done_n;
  usr_step #(.WIDTH(WIDTH)) u_step (
    .q      (q),
    .mode   (state == ST_RUN ? mode_l : mode),
    .sin_lsb(sin_lsb),
    .sin_msb(sin_msb),
    .pdata  (pdata),
    .q_next (q_step)
  );
  assign sout_msb = q[WIDTH-1];
  assign sout_lsb = q[0];
  assign busy     = state == ST_RUN;
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mode_n  = mode_l;
    q_n     = q;
    done_n  = 1'b0;
    if (state == ST_RUN) begin
      q_n   = q_step;
      cnt_n = cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
    end else if (start) begin
      if (mode == MODE_LOAD || count == '0) begin
        q_n    = mode == MODE_LOAD ? pdata : q;
        done_n = 1'b1;
      end else begin
        mode_n  = mode;
        cnt_n   = count;
        state_n = ST_RUN;
      end
    end else if (en) begin
      q_n = q_step;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_l <= MODE_HOLD;
      q      <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      mode_l <= mode_n;
      q      <= q_n;
      done   <= done_n;
    end
  end
`ifdef USR_PARITY_EN
  always_ff @(posedge clk)
    parity <= rst ? 1'b0 : ^q_n;
`endif
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;
  import usr_pkg::*;
  logic       clk = 0, rst = 1, en = 0, sin_lsb = 0, sin_msb = 0, start = 0;
  logic [2:0] mode = MODE_HOLD;
  logic [7:0] pdata = 0, q;
  logic [3:0] count = 0;
  logic       sout_msb, sout_lsb, busy, done;
`ifdef USR_PARITY_EN
  logic       parity;
`endif
  int errs = 0, checks = 0;
  univ_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sin_lsb(sin_lsb), .sin_msb(sin_msb),
    .pdata(pdata), .start(start), .count(count), .q(q), .sout_msb(sout_msb),
    .sout_lsb(sout_lsb), .busy(busy), .done(done)
`ifdef USR_PARITY_EN
    , .parity(parity)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic stat(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".busy"}, busy, eb);
    chk({tag, ".done"}, done, ed);
  endtask
  task automatic load_en(input logic [7:0] v);
    en = 1; mode = MODE_LOAD; pdata = v;
    tick;
    en = 0; mode = MODE_HOLD;
    chk("load_en", q, v);
  endtask
  initial begin
    tick; tick;
    rst = 0;
    stat("reset", 8'h00, 0, 0);
    en = 1; mode = MODE_LOAD; pdata = 8'hA5;
    tick;
    stat("load", 8'hA5, 0, 0);
    chk("sout_msb", sout_msb, 1);
    chk("sout_lsb", sout_lsb, 1);
`ifdef USR_PARITY_EN
    chk("parity_a5", parity, 0);
`endif
    mode = MODE_SHL; sin_lsb = 1;
    tick;
    chk("shl", q, 8'h4B);
    mode = MODE_HOLD;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("hold", q, 8'h4B);
    end
    load_en(8'h00);
    en = 1; mode = MODE_SHR; sin_msb = 1;
    tick; chk("shr1", q, 8'h80);
    tick; chk("shr2", q, 8'hC0);
    chk("sout_lsb0", sout_lsb, 0);
    tick; chk("shr3", q, 8'hE0);
    tick; chk("shr4", q, 8'hF0);
    en = 0; sin_msb = 0;
`ifdef USR_PARITY_EN
    chk("parity_f0", parity, 0);
`endif
    load_en(8'h81);
    start = 1; mode = MODE_ROL; count = 3;
    tick;
    start = 0; mode = MODE_HOLD; count = 0;
    stat("rol_launch", 8'h81, 1, 0);
    tick;
    stat("rol1", 8'h03, 1, 0);
    start = 1; mode = MODE_SHL; count = 7; en = 1;
    tick;
    start = 0; mode = MODE_HOLD; count = 0; en = 0;
    stat("rol2", 8'h06, 1, 0);
    tick;
    stat("rol3", 8'h0C, 0, 1);
`ifdef USR_PARITY_EN
    chk("parity_0c", parity, 0);
`endif
    tick;
    stat("rol_after", 8'h0C, 0, 0);
    load_en(8'h3C);
    start = 1; mode = MODE_SHL; count = 0;
    tick;
    stat("cnt0", 8'h3C, 0, 1);
    mode = MODE_ROR; count = 2;
    tick;
    start = 0; mode = MODE_HOLD; count = 0;
    stat("start_on_done", 8'h3C, 1, 0);
    tick; stat("ror_a", 8'h1E, 1, 0);
    tick; stat("ror_b", 8'h0F, 0, 1);
    load_en(8'h01);
    start = 1; mode = MODE_ROR; count = 5;
    tick;
    start = 0; mode = MODE_HOLD; count = 0;
    stat("ror5_launch", 8'h01, 1, 0);
    tick; stat("ror5_1", 8'h80, 1, 0);
    tick; stat("ror5_2", 8'h40, 1, 0);
    rst = 1;
    tick;
    rst = 0;
    stat("abort", 8'h00, 0, 0);
`ifdef USR_PARITY_EN
    chk("parity_rst", parity, 0);
`endif
    tick;
    stat("abort_nodone", 8'h00, 0, 0);
    start = 1; mode = MODE_LOAD; count = 3; pdata = 8'h96;
    tick;
    start = 0; mode = MODE_HOLD; count = 0; pdata = 0;
    stat("burst_load", 8'h96, 0, 1);
    start = 1; mode = MODE_SHR; count = 2; sin_msb = 0;
    tick;
    start = 0; mode = MODE_HOLD; count = 0;
    stat("shr_launch", 8'h96, 1, 0);
    tick; stat("shr_b1", 8'h4B, 1, 0);
    sin_msb = 1;
    tick; stat("shr_b2", 8'hA5, 0, 1);
    tick; stat("shr_idle", 8'hA5, 0, 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
